sp_alu_issue: RTL and testbench
===============================

Name: sp_alu_issue

Overview:
- Issue/writeback controller that drives the SP core's combinational ALU.
- Accepts one 16-bit ALU instruction at a time over a valid/ready handshake.
- Reads three source operands from a local register file and presents them to the ALU with its 4-bit control code.
- Captures ALU_OUT and P, writes the result back to the register file and updates the predicate flag.

Parameters:
- DATA_W, 16, operand/result width; must match ALU.
- NREG, 8, number of registers in the local register file.
- MAX_OP, 9, highest legal ALU control code (0 = CLEAR ... 9).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  16  [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] rc.
- ld_valid  in  1  host register-file write strobe.
- ld_addr  in  3  host write address.
- ld_data  in  DATA_W  host write data.
- dbg_addr  in  3  debug read address.
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr].
- alu_a, alu_b, alu_c  out  DATA_W  registered operands to ALU.
- alu_ctrl  out  4  registered ALU control code.
- alu_out  in  DATA_W  ALU result (combinational from alu_*).
- alu_p  in  1  ALU predicate output.
- pred  out  1  registered predicate flag.
- done  out  1  one-cycle pulse per completed instruction.
- err  out  1  one-cycle pulse on illegal opcode.

Behaviour:
- Reset: when reset_n=0 at a rising edge:
  - all registers, alu_a/b/c, alu_ctrl, pred, done and err are set to 0;
  - state is set to IDLE;
  - instr_ready is forced 0 while reset_n=0.
- FSM states: IDLE, OPRD, EXEC, WB.
- instr_ready = (state==IDLE) & reset_n.
- IDLE:
  - On instr_valid & instr_ready, latch instr.
  - If op > MAX_OP: pulse err in the next cycle, stay in IDLE, leave regs and pred unchanged, never drive alu_ctrl.
  - Otherwise go to OPRD.
- OPRD:
  - alu_a <= reg[ra], alu_b <= reg[rb], alu_c <= reg[rc], alu_ctrl <= op.
  - Go to EXEC.
- EXEC: result_q <= alu_out, p_q <= alu_p; go to WB.
- WB:
  - reg[rd] <= result_q, pred <= p_q.
  - done=1 in the cycle after this edge; go to IDLE.
- Latency:
  - Instruction accepted at edge T.
  - Operands reach the ALU after T+1.
  - Result sampled at T+2.
  - Writeback at T+3, with done high during cycle T+3..T+4.
  - Next accept is possible at edge T+4.
  - Throughput: 1 instruction per 4 cycles.
- alu_a/b/c and alu_ctrl hold their values after EXEC until the next OPRD; they are not cleared.
- rd may equal ra, rb or rc: operands are already latched in OPRD, so writeback uses the old values.
- Host load:
  - ld_valid is honoured only in IDLE, where reg[ld_addr] <= ld_data.
  - In other states ld_valid is ignored; no error is flagged.
  - ld_valid and an instruction accept on the same IDLE edge: the load commits at that edge, so OPRD reads the new value.
- dbg_data is pure combinational from the register array and reflects writes from the following cycle.
- reset_n=0 mid-instruction (OPRD/EXEC/WB): abort with no writeback, no done, and clear all state as above.
- Arithmetic is wholly inside the ALU. The controller never modifies result width; DATA_W bits pass through unchanged.

Test Plan:
- Bench ALU stub: alu_out = alu_a ^ alu_b; alu_p = alu_c[0].
- Reset: hold reset_n=0 for 3 edges, then release:
  - instr_ready=0 during reset and 1 after;
  - pred=0, done=0;
  - dbg_data=0 for every address.
- Basic op: load r1=0x0019, r2=0x0002, r3=0x0005. Issue op=1, rd=4, ra=1, rb=2, rc=3:
  - alu_ctrl=1 and alu_a=0x0019 one edge after accept;
  - done exactly 3 edges after accept;
  - r4=0x001B, pred=1;
  - instr_ready low for exactly 3 cycles.
- Source overwrite: issue rd=1, ra=1, rb=1, rc=2 with r1=0x0019, r2=0x0002 -> r1=0x0000, pred=0.
- Illegal op: issue op=4'hC -> err pulses once, done never asserts, all regs unchanged, next instruction accepted on the following cycle.
- Load contention:
  - ld_valid in EXEC writing r4=0xFFFF is ignored: r4 holds the writeback value.
  - ld_valid with an accept in IDLE, loading r1=0x00F0 while issuing ra=1, rb=2: result 0x00F2.
- Mid-op reset: assert reset_n=0 in EXEC -> no done, all regs 0, instr_ready=1 the cycle after release.

Source files
------------

// File: rtl/sp_alu_issue.sv
// rtl/sp_alu_issue.sv - issue/writeback controller for the SP core's combinational ALU
// Reads three operands from a local register file, drives the ALU, writes the result back.
module sp_alu_issue #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int MAX_OP = 9
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   input  logic              ld_valid,
   input  logic [2:0]        ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] alu_c,
   output logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_p,
   output logic              pred,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, OPRD, EXEC, WB} state_t;

   localparam logic [3:0] MAX_OP_C = MAX_OP[3:0];

   state_t            state;
   logic [DATA_W-1:0] regs [NREG];
   logic [15:0]       instr_q;
   logic [DATA_W-1:0] result_q;
   logic              p_q;

   logic [3:0] op_q;
   logic [2:0] rd_q, ra_q, rb_q, rc_q;

   assign op_q = instr_q[15:12];
   assign rd_q = instr_q[11:9];
   assign ra_q = instr_q[8:6];
   assign rb_q = instr_q[5:3];
   assign rc_q = instr_q[2:0];

   assign instr_ready = (state == IDLE) & reset_n;
   assign dbg_data    = regs[dbg_addr];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         instr_q  <= '0;
         result_q <= '0;
         p_q      <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_c    <= '0;
         alu_ctrl <= '0;
         pred     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               // A load on the accept edge commits first, so OPRD sees the new value.
               if (ld_valid) regs[ld_addr] <= ld_data;
               if (instr_valid) begin
                  instr_q <= instr;
                  if (instr[15:12] > MAX_OP_C) err   <= 1'b1;
                  else                         state <= OPRD;
               end
            end
            OPRD: begin
               alu_a    <= regs[ra_q];
               alu_b    <= regs[rb_q];
               alu_c    <= regs[rc_q];
               alu_ctrl <= op_q;
               state    <= EXEC;
            end
            EXEC: begin
               result_q <= alu_out;
               p_q      <= alu_p;
               state    <= WB;
            end
            WB: begin
               regs[rd_q] <= result_q;
               pred       <= p_q;
               done       <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sp_alu_issue.sv
// tb/tb_sp_alu_issue.sv - self-checking bench for sp_alu_issue with an XOR ALU stub
module tb_sp_alu_issue;

   logic        clock;
   logic        reset_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        ld_valid;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;
   logic [15:0] alu_a, alu_b, alu_c;
   logic [3:0]  alu_ctrl;
   logic [15:0] alu_out;
   logic        alu_p;
   logic        pred, done, err;

   int vectors    = 0;
   int miscompares = 0;

   logic [15:0] m_regs [8];
   logic        m_pred;

   sp_alu_issue dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_c       (alu_c),
      .alu_ctrl    (alu_ctrl),
      .alu_out     (alu_out),
      .alu_p       (alu_p),
      .pred        (pred),
      .done        (done),
      .err         (err)
   );

   assign alu_out = alu_a ^ alu_b;
   assign alu_p   = alu_c[0];

   initial clock = 1'b0;
   always #10 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] mk(input int op, input int rd, input int ra, input int rb, input int rc);
      mk = {op[3:0], rd[2:0], ra[2:0], rb[2:0], rc[2:0]};
   endfunction

   // Reference: an accepted legal instruction computes ra^rb into rd, predicate from rc bit 0.
   task automatic model_exec(input logic [15:0] ins);
      logic [15:0] a, b, c;
      if (ins[15:12] > 4'd9) return;
      a = m_regs[ins[8:6]];
      b = m_regs[ins[5:3]];
      c = m_regs[ins[2:0]];
      m_regs[ins[11:9]] = a ^ b;
      m_pred = c[0];
   endtask

   task automatic host_load(input int a, input logic [15:0] d);
      ld_valid = 1'b1;
      ld_addr  = a[2:0];
      ld_data  = d;
      tick();
      ld_valid = 1'b0;
      m_regs[a] = d;
   endtask

   task automatic accept(input logic [15:0] ins);
      instr       = ins;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low: got %b expected 0", instr_ready);
         end
      end
      reset_n = 1'b1;
      #1;
      vectors++;
      if (instr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready_high: got %b expected 1", instr_ready);
      end
      vectors++;
      if (pred !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: pred=%b done=%b err=%b expected 0 0 0", pred, done, err);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = i[2:0];
         #1;
         vectors++;
         if (dbg_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_reg%0d: got %h expected 0000", i, dbg_data);
         end
         m_regs[i] = 16'h0000;
      end
      m_pred = 1'b0;
   endtask

   task automatic test_basic();
      int n;
      host_load(1, 16'h0019);
      host_load(2, 16'h0002);
      host_load(3, 16'h0005);
      accept(mk(1, 4, 1, 2, 3));
      model_exec(mk(1, 4, 1, 2, 3));
      vectors++;
      if (instr_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_ready_c1: got %b expected 0", instr_ready);
      end
      tick();
      vectors++;
      if (alu_ctrl !== 4'd1 || alu_a !== 16'h0019) begin
         miscompares++;
         $display("FAIL basic_operands: ctrl=%h a=%h expected 1 0019", alu_ctrl, alu_a);
      end
      vectors++;
      if (instr_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_ready_c2: got %b expected 0", instr_ready);
      end
      tick();
      vectors++;
      if (instr_ready !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_c3: ready=%b done=%b expected 0 0", instr_ready, done);
      end
      wait_done(n);
      vectors++;
      if (n != 1) begin
         miscompares++;
         $display("FAIL basic_done_latency: got %0d edges expected 3", n + 2);
      end
      vectors++;
      if (instr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_ready_back: got %b expected 1", instr_ready);
      end
      dbg_addr = 3'd4;
      #1;
      vectors++;
      if (dbg_data !== 16'h001B || pred !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_result: r4=%h pred=%b expected 001b 1", dbg_data, pred);
      end
      tick();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_done_pulse: got %b expected 0", done);
      end
   endtask

   task automatic test_overwrite();
      int n;
      accept(mk(2, 1, 1, 1, 2));
      model_exec(mk(2, 1, 1, 1, 2));
      wait_done(n);
      vectors++;
      if (n != 3) begin
         miscompares++;
         $display("FAIL overwrite_latency: got %0d expected 3", n);
      end
      dbg_addr = 3'd1;
      #1;
      vectors++;
      if (dbg_data !== 16'h0000 || pred !== 1'b0) begin
         miscompares++;
         $display("FAIL overwrite_result: r1=%h pred=%b expected 0000 0", dbg_data, pred);
      end
      tick();
   endtask

   task automatic test_illegal();
      int n;
      accept(mk(12, 3, 2, 3, 4));
      vectors++;
      if (err !== 1'b1 || done !== 1'b0 || instr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL illegal_flags: err=%b done=%b ready=%b expected 1 0 1", err, done, instr_ready);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = i[2:0];
         #1;
         vectors++;
         if (dbg_data !== m_regs[i]) begin
            miscompares++;
            $display("FAIL illegal_reg%0d: got %h expected %h", i, dbg_data, m_regs[i]);
         end
      end
      accept(mk(2, 5, 3, 1, 0));
      model_exec(mk(2, 5, 3, 1, 0));
      vectors++;
      if (err !== 1'b0 || instr_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_next_accept: err=%b ready=%b expected 0 0", err, instr_ready);
      end
      wait_done(n);
      dbg_addr = 3'd5;
      #1;
      vectors++;
      if (n != 3 || dbg_data !== m_regs[5] || pred !== m_pred) begin
         miscompares++;
         $display("FAIL illegal_followup: edges=%0d r5=%h pred=%b expected 3 %h %b", n, dbg_data, pred, m_regs[5], m_pred);
      end
      tick();
   endtask

   task automatic test_load_contention();
      int n;
      accept(mk(3, 4, 2, 3, 3));
      model_exec(mk(3, 4, 2, 3, 3));
      tick();
      ld_valid = 1'b1;
      ld_addr  = 3'd4;
      ld_data  = 16'hFFFF;
      tick();
      ld_valid = 1'b0;
      wait_done(n);
      dbg_addr = 3'd4;
      #1;
      vectors++;
      if (dbg_data !== m_regs[4]) begin
         miscompares++;
         $display("FAIL exec_load_ignored: r4=%h expected %h", dbg_data, m_regs[4]);
      end
      tick();
      ld_valid = 1'b1;
      ld_addr  = 3'd1;
      ld_data  = 16'h00F0;
      m_regs[1] = 16'h00F0;
      accept(mk(4, 6, 1, 2, 0));
      ld_valid = 1'b0;
      model_exec(mk(4, 6, 1, 2, 0));
      wait_done(n);
      dbg_addr = 3'd6;
      #1;
      vectors++;
      if (dbg_data !== 16'h00F2 || n != 3) begin
         miscompares++;
         $display("FAIL idle_load_accept: r6=%h edges=%0d expected 00f2 3", dbg_data, n);
      end
      tick();
   endtask

   task automatic test_random();
      int n, op;
      logic [15:0] ins;
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 1) == 1)
            host_load($urandom_range(0, 7), 16'($urandom));
         op  = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
         ins = mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
         vectors++;
         if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rand%0d_ready: got %b expected 1", k, instr_ready);
         end
         accept(ins);
         model_exec(ins);
         if (op > 9) begin
            vectors++;
            if (err !== 1'b1 || done !== 1'b0) begin
               miscompares++;
               $display("FAIL rand%0d_illegal: err=%b done=%b expected 1 0", k, err, done);
            end
         end else begin
            wait_done(n);
            vectors++;
            if (n != 3) begin
               miscompares++;
               $display("FAIL rand%0d_latency: got %0d expected 3", k, n);
            end
         end
         vectors++;
         if (pred !== m_pred) begin
            miscompares++;
            $display("FAIL rand%0d_pred: got %b expected %b", k, pred, m_pred);
         end
         for (int i = 0; i < 8; i++) begin
            dbg_addr = i[2:0];
            #1;
            vectors++;
            if (dbg_data !== m_regs[i]) begin
               miscompares++;
               $display("FAIL rand%0d_reg%0d: got %h expected %h", k, i, dbg_data, m_regs[i]);
            end
         end
         tick();
      end
   endtask

   task automatic test_midop_reset();
      host_load(7, 16'h1234);
      accept(mk(5, 7, 7, 0, 7));
      tick();
      reset_n = 1'b0;
      tick();
      vectors++;
      if (done !== 1'b0 || instr_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_in_reset: done=%b ready=%b expected 0 0", done, instr_ready);
      end
      reset_n = 1'b1;
      tick();
      vectors++;
      if (done !== 1'b0 || instr_ready !== 1'b1 || pred !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_after: done=%b ready=%b pred=%b expected 0 1 0", done, instr_ready, pred);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = i[2:0];
         #1;
         vectors++;
         if (dbg_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL midop_reg%0d: got %h expected 0000", i, dbg_data);
         end
      end
      tick();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_no_late_done: got %b expected 0", done);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      ld_valid    = 1'b0;
      ld_addr     = '0;
      ld_data     = '0;
      dbg_addr    = '0;
      test_reset();
      test_basic();
      test_overwrite();
      test_illegal();
      test_load_contention();
      test_random();
      test_midop_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
